// File: rtl/dispatch_pkg.sv
// Shared constants, station ids and payload types for the dispatch stage.
// Also holds the per-operand source resolution helper.
package dispatch_pkg;

   localparam int unsigned NUM_STATIONS = 4;
   localparam int unsigned RS_DEPTH     = 2;
   localparam int unsigned IDX_W        = $clog2(RS_DEPTH);
   localparam int unsigned SID_W        = 2;
   localparam int unsigned TAG_W        = SID_W + IDX_W;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned REG_W        = 5;
   localparam int unsigned NUM_REGS     = 32;
   localparam int unsigned STN_W        = 4;
   localparam int unsigned FN_W         = 6;
   localparam int unsigned IMM_W        = 16;

   localparam logic [STN_W-1:0] STATION_NONE   = 4'd0;
   localparam logic [STN_W-1:0] STATION_ALU    = 4'd1;
   localparam logic [STN_W-1:0] STATION_MULDIV = 4'd2;
   localparam logic [STN_W-1:0] STATION_BRANCH = 4'd3;
   localparam logic [STN_W-1:0] STATION_MEM    = 4'd4;

   typedef struct packed {
      logic              ready;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] val;
   } operand_t;

   typedef struct packed {
      logic             busy;
      logic [TAG_W-1:0] tag;
   } reg_status_t;

   // Unused/r0 operands are ready zero; busy operands may be bypassed from the CDB.
   function automatic operand_t resolve_operand(
      input logic              has_reg,
      input logic [REG_W-1:0]  idx,
      input reg_status_t       st,
      input logic [DATA_W-1:0] rf_data,
      input logic              cdb_valid,
      input logic [TAG_W-1:0]  cdb_tag,
      input logic [DATA_W-1:0] cdb_data
   );
      operand_t op;
      op = '0;
      if (!has_reg || idx == '0) begin
         op.ready = 1'b1;
      end else if (!st.busy) begin
         op.ready = 1'b1;
         op.val   = rf_data;
      end else if (cdb_valid && cdb_tag == st.tag) begin
         op.ready = 1'b1;
         op.val   = cdb_data;
      end else begin
         op.tag = st.tag;
      end
      return op;
   endfunction

endpackage

// File: rtl/dispatch_unit_reg_status.sv
// Register status table: busy/producer-tag per architectural register.
// Two combinational lookups, one dispatch write, CDB tag-match clear.
module reg_status_table
   import dispatch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rd_addr_1,
   input  logic [REG_W-1:0] rd_addr_2,
   output reg_status_t      rd_status_1_c,
   output reg_status_t      rd_status_2_c,
   input  logic             wr_en,
   input  logic [REG_W-1:0] wr_addr,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag
);

   reg_status_t status_q [NUM_REGS];

   assign rd_status_1_c = status_q[rd_addr_1];
   assign rd_status_2_c = status_q[rd_addr_2];

   // The dispatch write comes last so it wins over a same-cycle CDB clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) status_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cdb_valid && status_q[i].busy && status_q[i].tag == cdb_tag)
               status_q[i].busy <= 1'b0;
         end
         if (wr_en && wr_addr != '0)
            status_q[wr_addr] <= '{busy: 1'b1, tag: wr_tag};
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: resolves operands, allocates a reservation-station slot
// and issues a registered entry one cycle after acceptance.
module dispatch_unit
   import dispatch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [STN_W-1:0]  rs_station,
   input  logic [FN_W-1:0]   alu_fn,
   input  logic [REG_W-1:0]  register_1,
   input  logic [REG_W-1:0]  register_2,
   input  logic [REG_W-1:0]  register_target,
   input  logic              has_register_1,
   input  logic              has_register_2,
   input  logic              has_target,
   input  logic [IMM_W-1:0]  immediate,
   output logic [REG_W-1:0]  rf_addr_1,
   output logic [REG_W-1:0]  rf_addr_2,
   input  logic [DATA_W-1:0] rf_data_1,
   input  logic [DATA_W-1:0] rf_data_2,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              rel_valid,
   input  logic [TAG_W-1:0]  rel_tag,
   output logic              issue_valid,
   output logic [STN_W-1:0]  issue_station,
   output logic [TAG_W-1:0]  issue_tag,
   output logic [FN_W-1:0]   issue_alu_fn,
   output logic [IMM_W-1:0]  issue_imm,
   output logic              issue_has_dest,
   output logic              src1_ready,
   output logic              src2_ready,
   output logic [TAG_W-1:0]  src1_tag,
   output logic [TAG_W-1:0]  src2_tag,
   output logic [DATA_W-1:0] src1_val,
   output logic [DATA_W-1:0] src2_val,
   output logic              illegal_op
);

   logic [NUM_STATIONS-1:0][RS_DEPTH-1:0] free_q, free_next;
   logic [RS_DEPTH-1:0] sel_free;
   logic [SID_W-1:0]    station_idx;
   logic [IDX_W-1:0]    alloc_idx;
   logic [TAG_W-1:0]    alloc_tag;
   logic                station_ok;
   logic                accept_alloc;
   logic                status_wr;
   reg_status_t         status_1, status_2;
   operand_t            op_1, op_2;
   operand_t            src1_q, src2_q;

   assign rf_addr_1 = register_1;
   assign rf_addr_2 = register_2;

   assign station_ok   = (rs_station != STATION_NONE) && (rs_station <= STN_W'(NUM_STATIONS));
   assign station_idx  = SID_W'(rs_station - 4'd1);
   assign sel_free     = free_q[station_idx];
   assign in_ready     = !station_ok || (|sel_free);
   assign accept_alloc = in_valid && station_ok && (|sel_free);
   assign alloc_tag    = TAG_W'({station_idx, alloc_idx});
   assign status_wr    = accept_alloc && has_target && register_target != '0;

   // Lowest-index free slot of the target station.
   always_comb begin
      alloc_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (sel_free[i]) alloc_idx = IDX_W'(i);
      end
   end

   // Release sets, allocation clears; both apply in the same cycle.
   always_comb begin
      free_next = free_q;
      if (rel_valid)
         free_next[rel_tag[TAG_W-1 -: SID_W]][rel_tag[IDX_W-1:0]] = 1'b1;
      if (accept_alloc)
         free_next[station_idx][alloc_idx] = 1'b0;
   end

   reg_status_table u_status (
      .clk           (clk),
      .rst           (rst),
      .rd_addr_1     (register_1),
      .rd_addr_2     (register_2),
      .rd_status_1_c (status_1),
      .rd_status_2_c (status_2),
      .wr_en         (status_wr),
      .wr_addr       (register_target),
      .wr_tag        (alloc_tag),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag)
   );

   assign op_1 = resolve_operand(has_register_1, register_1, status_1, rf_data_1,
                                 cdb_valid, cdb_tag, cdb_data);
   assign op_2 = resolve_operand(has_register_2, register_2, status_2, rf_data_2,
                                 cdb_valid, cdb_tag, cdb_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         free_q         <= '1;
         issue_valid    <= 1'b0;
         illegal_op     <= 1'b0;
         issue_station  <= '0;
         issue_tag      <= '0;
         issue_alu_fn   <= '0;
         issue_imm      <= '0;
         issue_has_dest <= 1'b0;
         src1_q         <= '0;
         src2_q         <= '0;
      end else begin
         free_q      <= free_next;
         issue_valid <= accept_alloc;
         illegal_op  <= in_valid && !station_ok;
         if (accept_alloc) begin
            issue_station  <= rs_station;
            issue_tag      <= alloc_tag;
            issue_alu_fn   <= alu_fn;
            issue_imm      <= immediate;
            issue_has_dest <= has_target;
            src1_q         <= op_1;
            src2_q         <= op_2;
         end
      end
   end

   assign src1_ready = src1_q.ready;
   assign src1_tag   = src1_q.tag;
   assign src1_val   = src1_q.val;
   assign src2_ready = src2_q.ready;
   assign src2_tag   = src2_q.tag;
   assign src2_val   = src2_q.val;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed self-checking bench for dispatch_unit with hand-computed expectations.
module tb_dispatch_unit;
   import dispatch_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [STN_W-1:0]  rs_station;
   logic [FN_W-1:0]   alu_fn;
   logic [REG_W-1:0]  register_1, register_2, register_target;
   logic              has_register_1, has_register_2, has_target;
   logic [IMM_W-1:0]  immediate;
   logic [REG_W-1:0]  rf_addr_1, rf_addr_2;
   logic [DATA_W-1:0] rf_data_1, rf_data_2;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              rel_valid;
   logic [TAG_W-1:0]  rel_tag;
   logic              issue_valid;
   logic [STN_W-1:0]  issue_station;
   logic [TAG_W-1:0]  issue_tag;
   logic [FN_W-1:0]   issue_alu_fn;
   logic [IMM_W-1:0]  issue_imm;
   logic              issue_has_dest;
   logic              src1_ready, src2_ready;
   logic [TAG_W-1:0]  src1_tag, src2_tag;
   logic [DATA_W-1:0] src1_val, src2_val;
   logic              illegal_op;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dispatch_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs_station(rs_station), .alu_fn(alu_fn),
      .register_1(register_1), .register_2(register_2), .register_target(register_target),
      .has_register_1(has_register_1), .has_register_2(has_register_2), .has_target(has_target),
      .immediate(immediate), .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
      .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rel_valid(rel_valid), .rel_tag(rel_tag),
      .issue_valid(issue_valid), .issue_station(issue_station), .issue_tag(issue_tag),
      .issue_alu_fn(issue_alu_fn), .issue_imm(issue_imm), .issue_has_dest(issue_has_dest),
      .src1_ready(src1_ready), .src2_ready(src2_ready),
      .src1_tag(src1_tag), .src2_tag(src2_tag),
      .src1_val(src1_val), .src2_val(src2_val),
      .illegal_op(illegal_op)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      cdb_valid = 1'b0;
      rel_valid = 1'b0;
   endtask

   task automatic op(input logic [3:0] st, input logic [5:0] fn,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rt,
                     input logic h1, input logic h2, input logic ht,
                     input logic [15:0] imm, input logic [31:0] d1, input logic [31:0] d2);
      in_valid = 1'b1; rs_station = st; alu_fn = fn;
      register_1 = r1; register_2 = r2; register_target = rt;
      has_register_1 = h1; has_register_2 = h2; has_target = ht;
      immediate = imm; rf_data_1 = d1; rf_data_2 = d2;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      op(4'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0);
      in_valid = 1'b0;
      cdb_tag = '0; cdb_data = '0; rel_tag = '0;
      cyc(); cyc();
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_illegal", 32'(illegal_op), 32'd0);
      chk("rst_src1_val", src1_val, 32'd0);
      chk("rst_issue_tag", 32'(issue_tag), 32'd0);
      rst = 1'b0;

      // addiu r2,r1,5 -> station 1, tag 0
      op(4'd1, 6'h09, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 16'd5, 32'd7, 32'h0);
      #1 chk("addiu_ready", 32'(in_ready), 32'd1);
      chk("rf_addr_1", 32'(rf_addr_1), 32'd1);
      cyc();
      chk("addiu_valid", 32'(issue_valid), 32'd1);
      chk("addiu_station", 32'(issue_station), 32'd1);
      chk("addiu_tag", 32'(issue_tag), 32'd0);
      chk("addiu_fn", 32'(issue_alu_fn), 32'h09);
      chk("addiu_s1_ready", 32'(src1_ready), 32'd1);
      chk("addiu_s1_val", src1_val, 32'd7);
      chk("addiu_s2_ready", 32'(src2_ready), 32'd1);
      chk("addiu_imm", 32'(issue_imm), 32'd5);
      chk("addiu_dest", 32'(issue_has_dest), 32'd1);

      // addu r3,r2,r4: r2 pending on tag 0, takes slot 1
      op(4'd1, 6'h21, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 16'd0, 32'hdead, 32'h44);
      cyc();
      chk("addu_tag", 32'(issue_tag), 32'd1);
      chk("addu_s1_ready", 32'(src1_ready), 32'd0);
      chk("addu_s1_tag", 32'(src1_tag), 32'd0);
      chk("addu_s1_val", src1_val, 32'd0);
      chk("addu_s2_ready", 32'(src2_ready), 32'd1);
      chk("addu_s2_val", src2_val, 32'h44);

      // Third station-1 op: station full -> stall, fields hold
      op(4'd1, 6'h21, 5'd1, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 16'd0, 32'd7, 32'd7);
      #1 chk("full_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("full_no_issue", 32'(issue_valid), 32'd0);
      chk("full_tag_hold", 32'(issue_tag), 32'd1);

      // Release tag 0: not usable in the release cycle
      rel_valid = 1'b1; rel_tag = 3'd0;
      #1 chk("rel_same_cycle_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("rel_no_issue", 32'(issue_valid), 32'd0);
      rel_valid = 1'b0;
      #1 chk("rel_next_ready", 32'(in_ready), 32'd1);
      cyc();
      chk("third_valid", 32'(issue_valid), 32'd1);
      chk("third_tag", 32'(issue_tag), 32'd0);
      chk("third_s2_val", src2_val, 32'd7);

      // Free slot 1 of station 1
      idle(); rel_valid = 1'b1; rel_tag = 3'd1;
      cyc();
      chk("idle_no_issue", 32'(issue_valid), 32'd0);
      rel_valid = 1'b0;

      // addu r5,r2,r0 with CDB tag 0 bypass; r0 read as zero
      op(4'd1, 6'h21, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 16'd0, 32'hdead, 32'h99);
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h12;
      cyc();
      cdb_valid = 1'b0;
      chk("byp_tag", 32'(issue_tag), 32'd1);
      chk("byp_s1_ready", 32'(src1_ready), 32'd1);
      chk("byp_s1_val", src1_val, 32'h12);
      chk("byp_r0_ready", 32'(src2_ready), 32'd1);
      chk("byp_r0_val", src2_val, 32'd0);

      // Station 2: r2 now clear; r3 bypassed on tag 1 while r3 is rewritten
      op(4'd2, 6'h18, 5'd2, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 16'd0, 32'h77, 32'h33);
      cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h55;
      cyc();
      cdb_valid = 1'b0;
      chk("md_station", 32'(issue_station), 32'd2);
      chk("md_tag", 32'(issue_tag), 32'd2);
      chk("md_s1_val", src1_val, 32'h77);
      chk("md_s2_ready", 32'(src2_ready), 32'd1);
      chk("md_s2_val", src2_val, 32'h55);

      // Station 3: r3 busy on tag 2 (dispatch beat CDB clear), r5 cleared by CDB
      op(4'd3, 6'h04, 5'd3, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 16'd0, 32'h1, 32'h2);
      cyc();
      chk("br_tag", 32'(issue_tag), 32'd4);
      chk("br_s1_ready", 32'(src1_ready), 32'd0);
      chk("br_s1_tag", 32'(src1_tag), 32'd2);
      chk("br_s2_ready", 32'(src2_ready), 32'd1);
      chk("br_s2_val", src2_val, 32'h2);
      chk("br_dest", 32'(issue_has_dest), 32'd0);

      // Illegal station 0 writing r9
      op(4'd0, 6'h01, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 16'd0, 32'h0, 32'h0);
      #1 chk("ill_ready", 32'(in_ready), 32'd1);
      cyc();
      chk("ill_no_issue", 32'(issue_valid), 32'd0);
      chk("ill_pulse", 32'(illegal_op), 32'd1);
      chk("ill_station_hold", 32'(issue_station), 32'd3);
      idle();
      cyc();
      chk("ill_pulse_end", 32'(illegal_op), 32'd0);

      // r9 must still be not busy
      op(4'd4, 6'h23, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 32'hab, 32'h0);
      cyc();
      chk("mem_tag", 32'(issue_tag), 32'd6);
      chk("r9_ready", 32'(src1_ready), 32'd1);
      chk("r9_val", src1_val, 32'hab);

      // lui r0
      op(4'd4, 6'h0f, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 16'h1234, 32'h0, 32'h0);
      cyc();
      chk("lui_tag", 32'(issue_tag), 32'd7);
      chk("lui_dest", 32'(issue_has_dest), 32'd1);
      chk("lui_imm", 32'(issue_imm), 32'h1234);

      // Read r0 after lui r0
      op(4'd3, 6'h04, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 32'hffff, 32'h0);
      cyc();
      chk("r0_tag", 32'(issue_tag), 32'd5);
      chk("r0_ready", 32'(src1_ready), 32'd1);
      chk("r0_val", src1_val, 32'd0);

      // Station 1 is full (slots 0,1 held); reset mid-operation
      op(4'd1, 6'h21, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 32'h31, 32'h0);
      #1 chk("pre_rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'hee;
      cyc();
      rst = 1'b0;
      cdb_valid = 1'b0;
      chk("rst2_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst2_src1_val", src1_val, 32'd0);
      chk("rst2_tag", 32'(issue_tag), 32'd0);
      #1 chk("rst2_ready", 32'(in_ready), 32'd1);
      cyc();
      chk("post_rst_valid", 32'(issue_valid), 32'd1);
      chk("post_rst_tag", 32'(issue_tag), 32'd0);
      chk("post_rst_r3_ready", 32'(src1_ready), 32'd1);
      chk("post_rst_r3_val", src1_val, 32'h31);

      idle();
      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
